// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: latches detector rising edges, grants shared actuators by fixed priority (2>1>0), sequences ALERT/VENT/DONE.
// Registered outputs, grant one cycle after edge capture, no backpressure; `GAS_ALARM_ESCALATE_EN adds the escalate latch.
module gas_alarm_controller #(
  parameter int unsigned ALERT_TIMEOUT = 8,
  parameter int unsigned VENT_CYCLES   = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [2:0] gas_det_i,
  input  logic       ack_i,
  output logic       siren_o,
  output logic       fan_o,
  output logic       valve_close_o,
  output logic [1:0] alarm_id_o,
  output logic [2:0] pending_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       escalate_o
);

  typedef enum logic [1:0] {S_IDLE, S_ALERT, S_VENT, S_DONE} state_t;

  localparam logic [15:0] ALERT_LAST = 16'(ALERT_TIMEOUT - 1);
  localparam logic [15:0] VENT_LAST  = 16'(VENT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  gas_det_q;
  logic [2:0]  pending_q, pending_d;
  logic [1:0]  alarm_id_q, alarm_id_d;
  logic [2:0]  rise;
  logic [2:0]  grant_mask;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alarm_id_d = alarm_id_q;
    grant_mask = 3'b000;
    rise       = gas_det_i & ~gas_det_q;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d = S_ALERT;
          cnt_d   = '0;
          if (pending_q[2]) begin
            grant_mask = 3'b100;
            alarm_id_d = 2'd3;
          end else if (pending_q[1]) begin
            grant_mask = 3'b010;
            alarm_id_d = 2'd2;
          end else begin
            grant_mask = 3'b001;
            alarm_id_d = 2'd1;
          end
        end
      end
      S_ALERT: begin
        if (ack_i || (cnt_q == ALERT_LAST)) begin
          state_d = S_VENT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VENT: begin
        if (cnt_q == VENT_LAST) begin
          state_d    = S_DONE;
          alarm_id_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A fresh rising edge on the bit being granted keeps it pending.
    pending_d = (pending_q & ~grant_mask) | rise;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gas_det_q  <= '0;
      pending_q  <= '0;
      alarm_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gas_det_q  <= gas_det_i;
      pending_q  <= pending_d;
      alarm_id_q <= alarm_id_d;
    end
  end

`ifdef GAS_ALARM_ESCALATE_EN
  logic esc_q, esc_d;

  always_comb begin
    esc_d = esc_q;
    if (ack_i) begin
      esc_d = 1'b0;
    end else if (state_q == S_ALERT && cnt_q == ALERT_LAST) begin
      esc_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      esc_q <= 1'b0;
    end else begin
      esc_q <= esc_d;
    end
  end

  assign escalate_o    = esc_q;
  assign valve_close_o = (state_q == S_ALERT) || (state_q == S_VENT) || esc_q;
`else
  assign escalate_o    = 1'b0;
  assign valve_close_o = (state_q == S_ALERT) || (state_q == S_VENT);
`endif

  assign siren_o    = (state_q == S_ALERT);
  assign fan_o      = (state_q == S_VENT);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign alarm_id_o = alarm_id_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Randomised and directed bench for gas_alarm_controller against a cycle-level behavioural model.
module tb_gas_alarm_controller;
  localparam int AT = 8;
  localparam int VC = 16;
  localparam int PH_IDLE = 0, PH_ALERT = 1, PH_VENT = 2, PH_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] gas_det;
  logic       ack;
  logic       siren, fan, valve_close, busy, done, escalate;
  logic [1:0] alarm_id;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gas_alarm_controller #(.ALERT_TIMEOUT(AT), .VENT_CYCLES(VC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .gas_det_i(gas_det), .ack_i(ack),
    .siren_o(siren), .fan_o(fan), .valve_close_o(valve_close),
    .alarm_id_o(alarm_id), .pending_o(pending), .busy_o(busy),
    .done_o(done), .escalate_o(escalate)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase + cycles spent in phase, pending set, service id.
  int         m_ph = PH_IDLE;
  int         m_age = 0;
  int         m_top;
  logic [1:0] m_id = 2'd0;
  logic [2:0] m_pend = 3'b000, m_prev = 3'b000, m_rise, m_nxt;
  logic       m_esc = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = PH_IDLE; m_age = 0; m_id = 2'd0; m_pend = 3'b000; m_prev = 3'b000; m_esc = 1'b0;
    end else begin
      m_rise = gas_det & ~m_prev;
      m_prev = gas_det;
      m_nxt  = m_pend;
      if (ack) m_esc = 1'b0;
      case (m_ph)
        PH_IDLE: if (m_pend != 3'b000) begin
          m_top = 0;
          for (int n = 0; n < 3; n++) if (m_pend[n]) m_top = n;
          m_nxt[m_top] = 1'b0;
          m_id  = 2'(m_top + 1);
          m_ph  = PH_ALERT;
          m_age = 0;
        end
        PH_ALERT: begin
          m_age++;
          if (ack) begin
            m_ph = PH_VENT; m_age = 0;
          end else if (m_age == AT) begin
            m_ph = PH_VENT; m_age = 0;
`ifdef GAS_ALARM_ESCALATE_EN
            m_esc = 1'b1;
`endif
          end
        end
        PH_VENT: begin
          m_age++;
          if (m_age == VC) begin
            m_ph = PH_DONE; m_id = 2'd0;
          end
        end
        default: m_ph = PH_IDLE;
      endcase
      m_pend = m_nxt | m_rise;
    end
  end

  always @(negedge clk) begin
    check("model_cycle",
          int'({siren, fan, valve_close, alarm_id, pending, busy, done, escalate}),
          int'({m_ph == PH_ALERT, m_ph == PH_VENT,
                (m_ph == PH_ALERT) || (m_ph == PH_VENT) || m_esc,
                m_id, m_pend, m_ph != PH_IDLE, m_ph == PH_DONE, m_esc}));
  end

  task automatic run_service(input int ack_at, input int refire_at,
                             output int waits, output int id, output logic [2:0] pend0,
                             output int s_cnt, output int f_cnt, output int d_cnt);
    waits = 0; id = 0; pend0 = 3'b000; s_cnt = 0; f_cnt = 0; d_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) break;
      waits++;
    end
    if (!busy) begin
      check("svc_start_timeout", 0, 1);
      return;
    end
    id    = int'(alarm_id);
    pend0 = pending;
    for (int i = 0; i < 200 && busy; i++) begin
      if (siren) begin
        s_cnt++;
        ack = (ack_at > 0) && (s_cnt == ack_at);
      end else begin
        ack = 1'b0;
      end
      if (fan) begin
        f_cnt++;
        if (refire_at > 0 && f_cnt == refire_at) gas_det[2] = 1'b0;
        if (refire_at > 0 && f_cnt == refire_at + 1) gas_det[2] = 1'b1;
      end
      if (done) d_cnt++;
      @(negedge clk);
    end
    if (busy) check("svc_end_timeout", 0, 1);
    ack = 1'b0;
  endtask

  initial begin
    int w, id, s, f, d, fc;
    logic [2:0] p0;

    rst_n = 1'b0; gas_det = 3'b111; ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs_zero",
            int'({siren, fan, valve_close, alarm_id, pending, busy, done, escalate}), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("pending_after_release", int'(pending), 7);
    check("idle_after_release", int'(busy), 0);
    rst_n = 1'b0; gas_det = 3'b000;
    @(negedge clk);
    check("reset_clear", int'({siren, fan, valve_close, alarm_id, pending, busy, done, escalate}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single alarm on bit 0, ack in the third ALERT cycle.
    gas_det = 3'b001;
    run_service(3, 0, w, id, p0, s, f, d);
    check("t2_wait", w, 1);
    check("t2_id", id, 1);
    check("t2_siren_cycles", s, 3);
    check("t2_fan_cycles", f, 16);
    check("t2_done_pulses", d, 1);
    check("t2_busy_after", int'(busy), 0);

    // Simultaneous rises on bits 0 and 1.
    gas_det = 3'b000;
    @(negedge clk);
    gas_det = 3'b011;
    run_service(1, 0, w, id, p0, s, f, d);
    check("t3_first_id", id, 2);
    check("t3_pending_during", int'(p0), 1);
    check("t3_siren_cycles", s, 1);
    run_service(1, 0, w, id, p0, s, f, d);
    check("t3_back_to_back_wait", w, 0);
    check("t3_second_id", id, 1);

    // Timeout without ack.
    gas_det = 3'b000;
    @(negedge clk);
    gas_det = 3'b001;
    run_service(0, 0, w, id, p0, s, f, d);
    check("t4_siren_timeout_cycles", s, 8);
    check("t4_fan_cycles", f, 16);
`ifdef GAS_ALARM_ESCALATE_EN
    check("t4_escalate_idle", int'(escalate), 1);
    check("t4_valve_idle", int'(valve_close), 1);
`else
    check("t4_escalate_idle", int'(escalate), 0);
    check("t4_valve_idle", int'(valve_close), 0);
`endif
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("t4_escalate_cleared", int'(escalate), 0);
    check("t4_valve_cleared", int'(valve_close), 0);

    // Bit 2 drops and re-rises during VENT of its own service.
    gas_det = 3'b100;
    run_service(1, 5, w, id, p0, s, f, d);
    check("t5_id", id, 3);
    check("t5_repending", int'(pending), 4);
    run_service(1, 0, w, id, p0, s, f, d);
    check("t5_reservice_wait", w, 0);
    check("t5_reservice_id", id, 3);

    // Reset pulse in the middle of VENT.
    gas_det = 3'b110;
    fc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fan) fc++;
      if (fc == 4) break;
    end
    check("t6_reached_vent", fc, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_reset_mid_vent", int'({fan, busy, alarm_id, pending}), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) gas_det[$urandom_range(0, 2)] ^= 1'b1;
      ack   = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gas_alarm_controller.md
# gas_alarm_controller

- Sequences the home's shared gas-response actuators: siren, exhaust fan and supply-valve close.
- Takes the three per-gas alarm flags from the gas detector sensor, latches new alarms and grants the actuators to one alarm at a time by fixed priority.
- Runs each granted alarm through an alert / ventilate / done sequence, with a user-acknowledge handshake and a timeout.

## Interface
Parameters:
- ALERT_TIMEOUT, 8: max ALERT-state cycles without ack; legal 1..65535
- VENT_CYCLES, 16: VENT-state duration in cycles; legal 1..65535

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- gas_det  in  3  detector alarm flags (level); bit n = gas type n
- ack  in  1  user acknowledge, level, sampled every cycle
- siren  out  1  siren drive
- fan  out  1  exhaust fan drive
- valve_close  out  1  supply valve close command
- alarm_id  out  2  alarm in service: 0 none, n+1 = gas bit n
- pending  out  3  latched, not-yet-serviced alarms
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on completion of a service
- escalate  out  1  unacknowledged-alarm flag; tied 0 without macro

## Operation
- Edge capture: gas_det_q registers gas_det.
  - gas_det[n]=1 with gas_det_q[n]=0 sets pending[n].
  - A level held high does not re-request.
- States: IDLE, ALERT, VENT, DONE. One 16-bit counter cnt.
- IDLE, pending != 0:
  - Grant the highest set bit (priority 2 > 1 > 0).
  - Clear that pending bit and set alarm_id = n+1.
  - cnt = 0, go to ALERT.
  - With pending == 0, stay in IDLE.
- ALERT: siren=1, valve_close=1, fan=0.
  - ack=1: go to VENT, cnt=0.
  - Else, when cnt == ALERT_TIMEOUT-1: timeout, go to VENT, cnt=0.
  - Else cnt++.
- VENT: fan=1, valve_close=1, siren=0.
  - When cnt == VENT_CYCLES-1: go to DONE.
  - Else cnt++.
  - ack is ignored except for clearing escalate.
- DONE: done=1, all actuators 0, alarm_id=0, go to IDLE.
- Simultaneous grant-clear and new rising edge on the same bit: the set wins, so the bit remains pending.
- Rising edges during ALERT/VENT/DONE are latched normally; there is no preemption.
- ack in IDLE or DONE has no effect on the FSM.

## Timing
- All outputs are registered and decoded from state/registers. Every output resets to 0.
  - State resets to IDLE, cnt to 0, gas_det_q to 0.
- A gas_det that is high across reset release is seen as a new rising edge on the first cycle after release.
- Rising edge sampled at edge k: pending[n]=1 after k; grant at k+1 (ALERT, siren=1, alarm_id valid after k+1).
- ALERT lasts until the cycle ack is sampled high (minimum 1 cycle), or exactly ALERT_TIMEOUT cycles.
- VENT lasts exactly VENT_CYCLES cycles; DONE lasts exactly 1 cycle.
- Back-to-back requests: the next grant happens in IDLE one cycle after DONE.
- Reset mid-operation: state is IDLE at the next edge with rst_n low.
  - All outputs and pending go to 0; any in-flight service is dropped.

## Configuration
- Macro GAS_ALARM_ESCALATE_EN.
- Defined:
  - An ALERT timeout sets escalate=1 on VENT entry.
  - escalate stays 1 through subsequent services until ack is sampled high in any state, or reset.
  - While escalate=1, valve_close is forced 1 in all states, including IDLE.
- Undefined:
  - escalate is constant 0.
  - A timeout only advances to VENT.
  - valve_close is as per state.

## Test plan
- Hold rst_n=0 for 2 cycles with gas_det=3'b111 -> all outputs 0 during reset; pending=3'b111 one cycle after release.
- Rise on gas_det[0], ack after 3 ALERT cycles, VENT_CYCLES=16 -> alarm_id=1; siren high 3 cycles, then fan high 16 cycles; done one-cycle pulse; busy low afterwards.
- gas_det 3'b000 -> 3'b011 in one cycle -> id 2 serviced first with pending=3'b001; id 1 granted one cycle after the first done.
- No ack, ALERT_TIMEOUT=8 -> siren exactly 8 cycles.
  - With macro: escalate=1 from VENT entry and valve_close=1 in IDLE, until an ack pulse clears both.
  - Without macro: escalate stays 0.
- gas_det[2] falls then rises during VENT of id 3 -> pending[2]=1; id 3 serviced again right after DONE.
- rst_n low for one cycle in the middle of VENT -> next cycle fan=0, busy=0, alarm_id=0, pending=0.
